mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning), one clock domain.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset; shared with the memory block.
- ifReq  in  1  fetch request; held until ifGnt.
- ifAddr  in  32  fetch address; word reads only.
- ifGnt  out  1  one-cycle pulse: fetch request latched.
- ifDone  out  1  one-cycle pulse: fetch data valid.
- ifRData  out  32  fetch data; valid from ifDone, held until the next ifDone.
- lsReq  in  1  load/store request; held until lsGnt.
- lsWrite  in  1  1 = store.
- lsSize  in  2  00 byte, 01 half, 10 word.
- lsSign  in  1  sign-extend loads.
- lsAddr  in  32  byte address.
- lsWData  in  32  store data.
- lsGnt  out  1  one-cycle pulse: load/store request latched.
- lsDone  out  1  one-cycle pulse: access complete.
- lsErr  out  1  qualifies lsDone; misaligned access.
- lsRData  out  32  load data; valid from lsDone, held until the next lsDone.
- memReady  in  1  from memory.
- dataReady  in  1  from memory.
- memRData  in  32  memory outputData.
- memExecute  out  1  to memory.
- memWrite  out  1  to memory.
- memSize  out  2  to memory.
- memSign  out  1  to memory.
- memAddress  out  32  to memory.
- memWData  out  32  memory inputData.

Function
REQ-002 SHALL implement states IDLE, ISSUE, BUSY.
REQ-003 IDLE: when memReady=1 and any request is pending, SHALL pick a winner, latch its fields into the mem* registers, pulse the winner's Gnt, and go to ISSUE.
- A fetch latches as a word read with memSign=0.
REQ-004 A load/store whose address is misaligned SHALL NOT reach memory.
- Misaligned: half with lsAddr[0]=1; word with lsAddr[1:0]!=0.
- Same cycle: pulse lsGnt; next cycle: pulse lsDone with lsErr=1 and lsRData unchanged; state stays IDLE.
REQ-005 ISSUE: memExecute SHALL be 1; stay in ISSUE until memReady=0 is sampled, then deassert memExecute and go to BUSY.
REQ-006 BUSY: when memReady=1 is sampled, SHALL:
- capture memRData into the winner's RData, for reads only;
- pulse the winner's Done with lsErr=0;
- return to IDLE.
REQ-007 memAddress, memWrite, memSize, memSign, memWData SHALL stay constant from ISSUE entry through BUSY exit, because memory decodes the address combinationally during the whole access.
REQ-008 At most one access SHALL be outstanding; new requests SHALL NOT be granted outside IDLE.
REQ-009 Gnt and Done SHALL never be asserted for both ports in the same cycle.
REQ-010 A port may raise its next Req in the cycle its Done pulses; it SHALL be granted no earlier than the following IDLE cycle.
REQ-011 If memReady is still 1 in the cycle ISSUE is entered (memory restart phase), SHALL keep memExecute asserted; the access SHALL NOT be duplicated.

Reset
REQ-012 On reset SHALL:
- set the state to IDLE;
- drive all Gnt/Done/Err/memExecute low;
- zero all RData and mem* outputs;
- clear the round-robin pointer so ls is favoured.
REQ-013 Reset during ISSUE/BUSY SHALL abandon the access with no Done pulse.

Configuration
REQ-014 Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests the port not granted last wins; the pointer updates on every grant, including errors.
- Undefined: ls always wins over if; no pointer register is built.

Structure
REQ-015 Package mem_arb_pkg SHALL hold:
- the state enum;
- size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD;
- port ids PORT_IF, PORT_LS.
REQ-016 The winner selection SHALL be the sub-module mem_arb_select: 2 requests in, one-hot grant out, with the pointer internal and gated by the macro.

Verification
REQ-017 Fetch only: ifAddr=0x40, memory returns 0x00000013 -> one ifGnt, memExecute held until memReady=0, then ifDone with ifRData=0x00000013.
REQ-018 Store byte: lsAddr=0x103, lsWData=0xAB -> memWrite=1, memSize=00, memAddress=0x103 stable until lsDone; lsErr=0; ifDone stays 0.
REQ-019 Simultaneous ifReq/lsReq held for 4 accesses:
- fixed priority: ls, ls, ls, ls;
- MEM_ARB_ROUND_ROBIN_EN: ls, if, ls, if.
REQ-020 Misaligned: lsSize=10, lsAddr=0x6 -> lsGnt, then lsDone and lsErr next cycle; memExecute never asserted.
REQ-021 Reset asserted in BUSY -> no Done pulse, all outputs 0; a new fetch afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arbState_t;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SIZE_W    = 2;
    localparam int unsigned NUM_PORTS = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_LS = 1;

    // Half needs bit 0 clear, word needs bits 1:0 clear; bytes are always aligned.
    function automatic logic isMisaligned(input logic [SIZE_W-1:0] size, input logic [1:0] addrLo);
        case (size)
            SIZE_HALF: return addrLo[0];
            SIZE_WORD: return (addrLo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Two-port winner select; MEM_ARB_ROUND_ROBIN_EN builds a last-winner pointer,
// otherwise ls always wins over if.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 take,
    output logic [NUM_PORTS-1:0] gnt_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when ls won the last grant; cleared on reset so ls is favoured first.
    logic lastLs;

    always_ff @(posedge clk) begin
        if (reset) begin
            lastLs <= 1'b0;
        end else if (take) begin
            lastLs <= gnt_c[PORT_LS];
        end
    end

    always_comb begin
        gnt_c = '0;
        if (req[PORT_LS] && (!req[PORT_IF] || !lastLs)) begin
            gnt_c[PORT_LS] = 1'b1;
        end else if (req[PORT_IF]) begin
            gnt_c[PORT_IF] = 1'b1;
        end
    end
`else
    logic unusedFixed;
    assign unusedFixed = clk ^ reset ^ take;

    always_comb begin
        gnt_c = '0;
        if (req[PORT_LS]) begin
            gnt_c[PORT_LS] = 1'b1;
        end else if (req[PORT_IF]) begin
            gnt_c[PORT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (if) and load/store (ls) ports onto one memory, one access at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of ls-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ifReq,
    input  logic [DATA_W-1:0] ifAddr,
    output logic              ifGnt,
    output logic              ifDone,
    output logic [DATA_W-1:0] ifRData,
    input  logic              lsReq,
    input  logic              lsWrite,
    input  logic [SIZE_W-1:0] lsSize,
    input  logic              lsSign,
    input  logic [DATA_W-1:0] lsAddr,
    input  logic [DATA_W-1:0] lsWData,
    output logic              lsGnt,
    output logic              lsDone,
    output logic              lsErr,
    output logic [DATA_W-1:0] lsRData,
    input  logic              memReady,
    input  logic              dataReady,
    input  logic [DATA_W-1:0] memRData,
    output logic              memExecute,
    output logic              memWrite,
    output logic [SIZE_W-1:0] memSize,
    output logic              memSign,
    output logic [DATA_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWData
);

    arbState_t state, stateNxt;
    logic curLs, curLsNxt;
    logic errPend, errPendNxt;
    logic ifGntNxt, ifDoneNxt, lsGntNxt, lsDoneNxt, lsErrNxt;
    logic [DATA_W-1:0] ifRDataNxt, lsRDataNxt;
    logic memExecuteNxt, memWriteNxt, memSignNxt;
    logic [SIZE_W-1:0] memSizeNxt;
    logic [DATA_W-1:0] memAddressNxt, memWDataNxt;

    logic [NUM_PORTS-1:0] req, gntSel;
    logic take;

    // Completion is signalled by memReady alone; dataReady is not needed.
    logic unusedDataReady;
    assign unusedDataReady = dataReady;

    always_comb begin
        req          = '0;
        req[PORT_IF] = ifReq;
        req[PORT_LS] = lsReq;
    end

    // errPend blocks re-granting ls while its error grant is still visible.
    assign take = (state == IDLE) && memReady && !errPend && (ifReq || lsReq);

    mem_arb_select uSelect (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .take  (take),
        .gnt_c (gntSel)
    );

    always_comb begin
        stateNxt      = state;
        curLsNxt      = curLs;
        errPendNxt    = 1'b0;
        ifGntNxt      = 1'b0;
        ifDoneNxt     = 1'b0;
        lsGntNxt      = 1'b0;
        lsDoneNxt     = 1'b0;
        lsErrNxt      = 1'b0;
        ifRDataNxt    = ifRData;
        lsRDataNxt    = lsRData;
        memExecuteNxt = memExecute;
        memWriteNxt   = memWrite;
        memSizeNxt    = memSize;
        memSignNxt    = memSign;
        memAddressNxt = memAddress;
        memWDataNxt   = memWData;

        if (errPend) begin
            lsDoneNxt = 1'b1;
            lsErrNxt  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (take) begin
                    if (gntSel[PORT_LS]) begin
                        lsGntNxt = 1'b1;
                        if (isMisaligned(lsSize, lsAddr[1:0])) begin
                            errPendNxt = 1'b1;
                        end else begin
                            curLsNxt      = 1'b1;
                            memExecuteNxt = 1'b1;
                            memWriteNxt   = lsWrite;
                            memSizeNxt    = lsSize;
                            memSignNxt    = lsSign;
                            memAddressNxt = lsAddr;
                            memWDataNxt   = lsWData;
                            stateNxt      = ISSUE;
                        end
                    end else begin
                        ifGntNxt      = 1'b1;
                        curLsNxt      = 1'b0;
                        memExecuteNxt = 1'b1;
                        memWriteNxt   = 1'b0;
                        memSizeNxt    = SIZE_WORD;
                        memSignNxt    = 1'b0;
                        memAddressNxt = ifAddr;
                        memWDataNxt   = '0;
                        stateNxt      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Memory may still show ready while restarting; wait for it to drop.
                if (!memReady) begin
                    memExecuteNxt = 1'b0;
                    stateNxt      = BUSY;
                end
            end
            BUSY: begin
                if (memReady) begin
                    if (curLs) begin
                        lsDoneNxt = 1'b1;
                        if (!memWrite) begin
                            lsRDataNxt = memRData;
                        end
                    end else begin
                        ifDoneNxt  = 1'b1;
                        ifRDataNxt = memRData;
                    end
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            curLs      <= 1'b0;
            errPend    <= 1'b0;
            ifGnt      <= 1'b0;
            ifDone     <= 1'b0;
            lsGnt      <= 1'b0;
            lsDone     <= 1'b0;
            lsErr      <= 1'b0;
            ifRData    <= '0;
            lsRData    <= '0;
            memExecute <= 1'b0;
            memWrite   <= 1'b0;
            memSize    <= '0;
            memSign    <= 1'b0;
            memAddress <= '0;
            memWData   <= '0;
        end else begin
            state      <= stateNxt;
            curLs      <= curLsNxt;
            errPend    <= errPendNxt;
            ifGnt      <= ifGntNxt;
            ifDone     <= ifDoneNxt;
            lsGnt      <= lsGntNxt;
            lsDone     <= lsDoneNxt;
            lsErr      <= lsErrNxt;
            ifRData    <= ifRDataNxt;
            lsRData    <= lsRDataNxt;
            memExecute <= memExecuteNxt;
            memWrite   <= memWriteNxt;
            memSize    <= memSizeNxt;
            memSign    <= memSignNxt;
            memAddress <= memAddressNxt;
            memWData   <= memWDataNxt;
        end
    end

endmodule
